// File: rtl/frame_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_ctrl_if
// Description : Frame pulses in, buffer ownership and addresses out, for the
//               triple-buffer scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_buffer_ctrl_if #(
    parameter int AXI_ADDR_WIDTH = 32
);
    logic                      wr_frame_start;
    logic                      wr_frame_done;
    logic                      rd_frame_start;
    logic [AXI_ADDR_WIDTH-1:0] wr_base_addr;
    logic [AXI_ADDR_WIDTH-1:0] rd_base_addr;
    logic [1:0]                wr_idx;
    logic [1:0]                rd_idx;
    logic                      rd_valid;
    logic [15:0]               drop_count;
    logic [15:0]               repeat_count;
    logic [1:0]                state;

    modport master (
        output wr_frame_start, wr_frame_done, rd_frame_start,
        input  wr_base_addr, rd_base_addr, wr_idx, rd_idx, rd_valid,
               drop_count, repeat_count, state
    );

    modport slave (
        input  wr_frame_start, wr_frame_done, rd_frame_start,
        output wr_base_addr, rd_base_addr, wr_idx, rd_idx, rd_valid,
               drop_count, repeat_count, state
    );
endinterface
`default_nettype wire

// File: rtl/frame_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_ctrl
// Description : Triple-buffer scheduler handing DDR frame base addresses to
//               the camera writer and the HDMI reader.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_ctrl #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BUF0_ADDR      = 32'h1000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] BUF_STRIDE     = 32'h0004_0000
) (
    input  logic                clk_100Mhz,
    input  logic                rst,
    frame_buffer_ctrl_if.slave  bus
);
    localparam logic [1:0]  c_st_idle    = 2'd0;
    localparam logic [1:0]  c_st_writing = 2'd1;
    localparam logic [1:0]  c_st_commit  = 2'd2;
    localparam logic [15:0] c_cnt_max    = 16'hFFFF;

    logic [1:0]                state_q, state_d;
    logic [1:0]                wr_idx_q, wr_idx_d;
    logic [1:0]                rd_idx_q, rd_idx_d;
    logic [1:0]                pend_idx_q, pend_idx_d;
    logic                      pend_new_q, pend_new_d;
    logic                      start_pend_q, start_pend_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [15:0]               drop_count_q, drop_count_d;
    logic [15:0]               repeat_count_q, repeat_count_d;
    logic [AXI_ADDR_WIDTH-1:0] wr_base_addr_q, wr_base_addr_d;
    logic [AXI_ADDR_WIDTH-1:0] rd_base_addr_q, rd_base_addr_d;

    // Ownership after the writer commit, before the reader is considered
    logic [1:0]                w_cm_wr_idx;
    logic [1:0]                w_cm_pend_idx;
    logic                      w_cm_pend_new;

    always_comb begin
        state_d        = state_q;
        start_pend_d   = start_pend_q;
        rd_valid_d     = rd_valid_q;
        drop_count_d   = drop_count_q;
        repeat_count_d = repeat_count_q;
        w_cm_wr_idx    = wr_idx_q;
        w_cm_pend_idx  = pend_idx_q;
        w_cm_pend_new  = pend_new_q;

        case (state_q)
            c_st_idle: begin
                if (bus.wr_frame_start) state_d = c_st_writing;
            end
            c_st_writing: begin
                if (bus.wr_frame_done) begin
                    state_d      = c_st_commit;
                    start_pend_d = bus.wr_frame_start;
                end else if (bus.wr_frame_start && drop_count_q != c_cnt_max) begin
                    drop_count_d = drop_count_q + 16'd1;
                end
            end
            c_st_commit: begin
                w_cm_wr_idx   = pend_idx_q;
                w_cm_pend_idx = wr_idx_q;
                w_cm_pend_new = 1'b1;
                rd_valid_d    = 1'b1;
                start_pend_d  = 1'b0;
                state_d = (start_pend_q || bus.wr_frame_start) ? c_st_writing : c_st_idle;
            end
            default: state_d = c_st_idle;
        endcase

        wr_idx_d   = w_cm_wr_idx;
        rd_idx_d   = rd_idx_q;
        pend_idx_d = w_cm_pend_idx;
        pend_new_d = w_cm_pend_new;

        // Reader sees the post-commit pending buffer, so a coincident commit is shown at once
        if (bus.rd_frame_start) begin
            if (w_cm_pend_new) begin
                rd_idx_d   = w_cm_pend_idx;
                pend_idx_d = rd_idx_q;
                pend_new_d = 1'b0;
            end else if (rd_valid_q && repeat_count_q != c_cnt_max) begin
                repeat_count_d = repeat_count_q + 16'd1;
            end
        end

        wr_base_addr_d = BUF0_ADDR + AXI_ADDR_WIDTH'(wr_idx_d) * BUF_STRIDE;
        rd_base_addr_d = BUF0_ADDR + AXI_ADDR_WIDTH'(rd_idx_d) * BUF_STRIDE;
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state_q        <= c_st_idle;
            wr_idx_q       <= 2'd0;
            rd_idx_q       <= 2'd1;
            pend_idx_q     <= 2'd2;
            pend_new_q     <= 1'b0;
            start_pend_q   <= 1'b0;
            rd_valid_q     <= 1'b0;
            drop_count_q   <= 16'd0;
            repeat_count_q <= 16'd0;
            wr_base_addr_q <= BUF0_ADDR;
            rd_base_addr_q <= BUF0_ADDR + BUF_STRIDE;
        end else begin
            state_q        <= state_d;
            wr_idx_q       <= wr_idx_d;
            rd_idx_q       <= rd_idx_d;
            pend_idx_q     <= pend_idx_d;
            pend_new_q     <= pend_new_d;
            start_pend_q   <= start_pend_d;
            rd_valid_q     <= rd_valid_d;
            drop_count_q   <= drop_count_d;
            repeat_count_q <= repeat_count_d;
            wr_base_addr_q <= wr_base_addr_d;
            rd_base_addr_q <= rd_base_addr_d;
        end
    end

    assign bus.state        = state_q;
    assign bus.wr_idx       = wr_idx_q;
    assign bus.rd_idx       = rd_idx_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.drop_count   = drop_count_q;
    assign bus.repeat_count = repeat_count_q;
    assign bus.wr_base_addr = wr_base_addr_q;
    assign bus.rd_base_addr = rd_base_addr_q;
endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buffer_ctrl
// Description : Directed vector bench for the triple-buffer scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_ctrl;
    localparam int          c_aw = 32;
    localparam logic [31:0] c_b0 = 32'h1000_0000;
    localparam logic [31:0] c_st = 32'h0004_0000;

    typedef struct {
        logic        ws;
        logic        wd;
        logic        rs;
        logic [1:0]  wr;
        logic [1:0]  rd;
        logic [1:0]  st;
        logic        v;
        logic [15:0] dr;
        logic [15:0] rp;
    } vec_t;

    logic clk_100Mhz = 1'b0;
    logic rst        = 1'b1;
    int   checks     = 0;
    int   errors     = 0;
    vec_t tbl [15];

    frame_buffer_ctrl_if #(.AXI_ADDR_WIDTH(c_aw)) bus ();

    frame_buffer_ctrl #(
        .AXI_ADDR_WIDTH (c_aw),
        .BUF0_ADDR      (c_b0),
        .BUF_STRIDE     (c_st)
    ) dut (
        .clk_100Mhz (clk_100Mhz),
        .rst        (rst),
        .bus        (bus)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input logic [1:0] i);
        return c_b0 + 32'(i) * c_st;
    endfunction

    task automatic chk(input string n, input logic [1:0] wr, input logic [1:0] rd,
                       input logic [1:0] st, input logic v, input logic [15:0] dr,
                       input logic [15:0] rp);
        cmp({n, ".wr_idx"},       32'(bus.wr_idx),       32'(wr));
        cmp({n, ".rd_idx"},       32'(bus.rd_idx),       32'(rd));
        cmp({n, ".wr_base_addr"}, bus.wr_base_addr,      addr_of(wr));
        cmp({n, ".rd_base_addr"}, bus.rd_base_addr,      addr_of(rd));
        cmp({n, ".state"},        32'(bus.state),        32'(st));
        cmp({n, ".rd_valid"},     32'(bus.rd_valid),     32'(v));
        cmp({n, ".drop_count"},   32'(bus.drop_count),   32'(dr));
        cmp({n, ".repeat_count"}, 32'(bus.repeat_count), 32'(rp));
    endtask

    task automatic step(input logic ws, input logic wd, input logic rs);
        bus.wr_frame_start = ws;
        bus.wr_frame_done  = wd;
        bus.rd_frame_start = rs;
        @(posedge clk_100Mhz);
        #1;
        bus.wr_frame_start = 1'b0;
        bus.wr_frame_done  = 1'b0;
        bus.rd_frame_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        bus.wr_frame_start = 1'b0;
        bus.wr_frame_done  = 1'b0;
        bus.rd_frame_start = 1'b0;

        //            ws    wd    rs    wr    rd    st    v     drop   rep
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd0, 1'b0, 16'd0, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0, 16'd0, 16'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 1'b0, 16'd0, 16'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 1'b0, 16'd1, 16'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 1'b0, 16'd2, 16'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd2, 1'b0, 16'd2, 16'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 1'b1, 16'd2, 16'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 1'b1, 16'd2, 16'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 1'b1, 16'd2, 16'd1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd1, 1'b1, 16'd2, 16'd1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 2'd2, 1'b1, 16'd2, 16'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd1, 1'b1, 16'd2, 16'd1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 2'd2, 1'b1, 16'd2, 16'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 2'd0, 1'b1, 16'd2, 16'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 2'd0, 1'b1, 16'd2, 16'd2};

        do_reset();
        chk("reset", 2'd0, 2'd1, 2'd0, 1'b0, 16'd0, 16'd0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].ws, tbl[i].wd, tbl[i].rs);
            chk($sformatf("vec%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].st,
                tbl[i].v, tbl[i].dr, tbl[i].rp);
        end

        // Long frame: start, done 100 cycles later, then display and repeat
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        chk("long.start", 2'd0, 2'd1, 2'd1, 1'b0, 16'd0, 16'd0);
        for (int i = 0; i < 99; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("long.done", 2'd0, 2'd1, 2'd2, 1'b0, 16'd0, 16'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("long.commit", 2'd2, 2'd1, 2'd0, 1'b1, 16'd0, 16'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("long.show", 2'd2, 2'd0, 2'd0, 1'b1, 16'd0, 16'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("long.repeat", 2'd2, 2'd0, 2'd0, 1'b1, 16'd0, 16'd1);

        // Reader vsync coincident with commit
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("coinc", 2'd2, 2'd0, 2'd0, 1'b1, 16'd0, 16'd0);
        cmp("coinc.pend_idx", 32'(2'd3 - bus.wr_idx - bus.rd_idx), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("coinc.after", 2'd2, 2'd0, 2'd0, 1'b1, 16'd0, 16'd1);

        // Reset while writing discards the frame
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_wr", 2'd0, 2'd1, 2'd0, 1'b0, 16'd0, 16'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("rst_wr.done_ign", 2'd0, 2'd1, 2'd0, 1'b0, 16'd0, 16'd0);

        // Reset while in commit
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_cm", 2'd0, 2'd1, 2'd0, 1'b0, 16'd0, 16'd0);

        // Repeat counter saturation
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65536; i++) step(1'b0, 1'b0, 1'b1);
        chk("sat", 2'd2, 2'd0, 2'd0, 1'b1, 16'd0, 16'hFFFF);
        step(1'b0, 1'b0, 1'b1);
        chk("sat.hold", 2'd2, 2'd0, 2'd0, 1'b1, 16'd0, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/frame_buffer_ctrl.md
Name: frame_buffer_ctrl

Overview:
- Triple-buffer scheduler between the camera-to-DDR writer path and the DDR-to-HDMI reader path.
- Owns three frame buffers in DDR and hands a base address to each side:
  - one buffer being written,
  - one being displayed,
  - one holding the newest complete frame.
- The writer never overwrites the displayed frame. The reader always gets the newest complete frame, or repeats its current one.
- Drives FRAME_BASE_ADDR of the AXI4 stream-to-memory writer and the base address of the HDMI frame reader.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- BUF0_ADDR, 32'h1000_0000, DDR byte address of buffer 0.
- BUF_STRIDE, 32'h0004_0000, byte distance between consecutive buffers; must be ≥ one frame (153,728 B).

Ports:
- clk_100Mhz  in  1  system/AXI clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_frame_start  in  1  one-cycle pulse: camera frame boundary, already synchronised to clk_100Mhz.
- wr_frame_done  in  1  one-cycle pulse: writer's last burst response received (writer_done).
- rd_frame_start  in  1  one-cycle pulse: HDMI reader needs a buffer for its next frame (vsync).
- wr_base_addr  out  AXI_ADDR_WIDTH  base address for the writer.
- rd_base_addr  out  AXI_ADDR_WIDTH  base address for the reader.
- wr_idx  out  2  buffer index currently owned by the writer.
- rd_idx  out  2  buffer index currently owned by the reader.
- rd_valid  out  1  at least one complete frame has ever been committed.
- drop_count  out  16  frames abandoned (restart before done), saturating.
- repeat_count  out  16  reader frames shown twice, saturating.
- state  out  2  writer-side FSM state (0 IDLE, 1 WRITING, 2 COMMIT).

Behaviour:
- Internal registers:
  - pend_idx: newest complete frame.
  - pend_new: pend_idx not yet shown.
  - start_pend: start pulse deferred across COMMIT.
- Invariant: {wr_idx, rd_idx, pend_idx} is always a permutation of {0,1,2}. Index value 3 never appears.
- Reset (sync):
  - wr_idx=0, rd_idx=1, pend_idx=2.
  - pend_new=0, start_pend=0, rd_valid=0.
  - drop_count=0, repeat_count=0, state=IDLE.
  - wr_base_addr=BUF0_ADDR; rd_base_addr=BUF0_ADDR+BUF_STRIDE.
- Base addresses: xx_base_addr = BUF0_ADDR + xx_idx*BUF_STRIDE, with the index zero-extended.
  - Registered and computed from the next-index values, so address and index change on the same clock edge.
  - Arithmetic is modulo 2^AXI_ADDR_WIDTH.
- Writer FSM:
  - IDLE:
    - wr_frame_start → WRITING.
    - wr_frame_done ignored; no state or counter change.
  - WRITING:
    - wr_frame_done → COMMIT.
    - wr_frame_start without done: drop_count+1, stay WRITING, same wr_idx (buffer is overwritten from the top).
    - Both pulses in the same cycle: go to COMMIT and set start_pend=1; no drop counted.
  - COMMIT (exactly 1 cycle):
    - Swap wr_idx↔pend_idx; pend_new=1; rd_valid=1.
    - Next state = WRITING if start_pend or wr_frame_start this cycle, else IDLE.
    - start_pend cleared.
- Reader (evaluated every cycle, independent of writer FSM):
  - rd_frame_start with pend_new=1: swap rd_idx↔pend_idx; pend_new=0.
  - rd_frame_start with pend_new=0 and rd_valid=1: repeat_count+1; rd_idx unchanged.
  - rd_frame_start with rd_valid=0: no change, no count.
- Simultaneous COMMIT and rd_frame_start: commit is applied first, then the reader swap.
  - Result: rd_idx=old wr_idx, wr_idx=old pend_idx, pend_idx=old rd_idx, pend_new=0.
  - repeat_count unchanged.
- Counters saturate at 16'hFFFF; no wrap.
- Outputs change only on clock edges; no combinational path from inputs to outputs.
- Reset asserted mid-WRITING or mid-COMMIT: everything returns to reset values on the next edge, and any in-flight frame is discarded.

Test Plan:
- Reset → wr_idx=0, rd_idx=1, wr_base_addr=0x1000_0000, rd_base_addr=0x1004_0000, rd_valid=0, state=0.
- wr_frame_start, 100 cycles later wr_frame_done → state 1→2→0; after COMMIT wr_idx=2, wr_base_addr=0x1008_0000, rd_valid=1. Then rd_frame_start → rd_idx=0, rd_base_addr=0x1000_0000, repeat_count=0.
- Continuing: rd_frame_start again with no new commit → repeat_count=1, rd_idx stays 0.
- wr_frame_start ×3 without wr_frame_done → drop_count=2, wr_idx unchanged, state=1.
- rd_frame_start in the same cycle as COMMIT (from reset-order indices 0/1/2) → rd_idx=0, wr_idx=2, pend_idx=1, pend_new=0, repeat_count=0.
- Coincident wr_frame_start+wr_frame_done → COMMIT then WRITING, drop_count=0.
- rst pulsed during WRITING → next cycle all reset values; 0xFFFF+ repeat events hold 0xFFFF.
